sap_data_ram: RTL and testbench

Parametrised single-clock data memory for the SAP datapath, the successor to the fixed 16×8 data RAM. It provides:
- one write port and one registered read port, with width and depth set by parameters;
- a `rd_valid` qualifier on read data;
- a hardware clear engine that zeroes every word after reset and on request.

It sits between the controller/sequencer and the accumulator/ALU data bus.

---
 rtl/sap_pkg.sv | 13 +
 rtl/sap_ram_clear_fsm.sv | 61 ++++++
 rtl/sap_data_ram.sv | 81 ++++++++
 tb/tb_sap_data_ram.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared SAP datapath definitions: default data-RAM geometry and the
// state encoding of the data-RAM clear engine.
package sap_pkg;

   localparam int SAP_DATA_W = 8;
   localparam int SAP_ADDR_W = 4;

   typedef enum logic {
      RAM_CLEAR = 1'b0,
      RAM_IDLE  = 1'b1
   } ram_state_t;

endpackage

// File: rtl/sap_ram_clear_fsm.sv
// Clear engine for sap_data_ram. Walks a pointer over every address,
// writing zero once per cycle, after reset and whenever a clear is requested
// from idle. While a clear runs, busy tells the top level to drop accesses.
module sap_ram_clear_fsm
   import sap_pkg::*;
#(
   parameter int DATA_W = SAP_DATA_W,
   parameter int ADDR_W = SAP_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_req,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr,
   output logic [DATA_W-1:0] clr_data
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   ram_state_t        state, state_nxt;
   logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;

   // State and pointer registers; reset lands in a clear from address 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RAM_CLEAR;
         clr_ptr <= '0;
      end else begin
         state   <= state_nxt;
         clr_ptr <= clr_ptr_nxt;
      end
   end

   // Next state: clear runs DEPTH cycles and ignores clr_req; idle re-arms on it.
   always_comb begin
      state_nxt   = state;
      clr_ptr_nxt = clr_ptr;
      clr_we      = 1'b0;
      case (state)
         RAM_CLEAR: begin
            clr_we      = 1'b1;
            clr_ptr_nxt = clr_ptr + 1'b1;   // wraps to 0 after the last word
            if (clr_ptr == LAST_ADDR) state_nxt = RAM_IDLE;
         end
         RAM_IDLE: begin
            clr_ptr_nxt = '0;
            if (clr_req) state_nxt = RAM_CLEAR;
         end
         default: begin
            state_nxt   = RAM_CLEAR;
            clr_ptr_nxt = '0;
         end
      endcase
   end

   assign busy     = (state == RAM_CLEAR);
   assign clr_addr = clr_ptr;
   assign clr_data = '0;

endmodule

// File: rtl/sap_data_ram.sv
// Parametrised single-clock SAP data RAM: one write port, one registered
// read port with rd_valid, and a hardware clear engine that zeroes the
// array after reset and on clr_req. Accesses arriving during a clear are
// dropped and flagged on access_drop the following cycle.
// Build option: define SAP_RAM_WR_BYPASS_EN for write-first behaviour on a
// same-address read/write; otherwise the read returns the old word.
module sap_data_ram
   import sap_pkg::*;
#(
   parameter int DATA_W = SAP_DATA_W,
   parameter int ADDR_W = SAP_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [DATA_W-1:0] data_in,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] read_addr,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid,
   input  logic              clr_req,
   output logic              busy,
   output logic              access_drop
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic [DATA_W-1:0] clr_data;
   logic              wr_ok, rd_ok;
   logic [DATA_W-1:0] rd_word;

   sap_ram_clear_fsm #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_clear (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_req  (clr_req),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .clr_data (clr_data)
   );

   // User accesses only reach the array when the clear engine is idle.
   assign wr_ok = wr_en & ~busy;
   assign rd_ok = rd_en & ~busy;

   // Array write port: the clear engine owns it while busy.
   always_ff @(posedge clk) begin
      if (clr_we)     mem[clr_addr]   <= clr_data;
      else if (wr_ok) mem[write_addr] <= data_in;
   end

   // Read word selection, including same-address collision policy.
   always_comb begin
      rd_word = mem[read_addr];
`ifdef SAP_RAM_WR_BYPASS_EN
      if (wr_en && (write_addr == read_addr)) rd_word = data_in;
`else
`endif
   end

   // Registered read data, valid qualifier and dropped-access pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out    <= '0;
         rd_valid    <= 1'b0;
         access_drop <= 1'b0;
      end else begin
         rd_valid    <= rd_ok;
         access_drop <= busy & (wr_en | rd_en);
         if (rd_ok) data_out <= rd_word;
      end
   end

endmodule

// File: tb/tb_sap_data_ram.sv
// Randomised scoreboard bench for sap_data_ram (default geometry) plus a
// directed check of a 16-bit x 64-word instance.
module tb_sap_data_ram;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 2 ** AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0, rd_en = 1'b0, clr_req = 1'b0;
   logic [AW-1:0] write_addr = '0, read_addr = '0;
   logic [DW-1:0] data_in = '0;
   logic [DW-1:0] data_out;
   logic          rd_valid, busy, access_drop;

   logic          b_rst_n = 1'b0;
   logic          b_we = 1'b0, b_re = 1'b0, b_clr = 1'b0;
   logic [5:0]    b_wa = '0, b_ra = '0;
   logic [15:0]   b_wd = '0;
   logic [15:0]   b_do;
   logic          b_rv, b_busy, b_drop;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   typedef struct {
      int            tag;
      logic [DW-1:0] d;
   } rd_exp_t;

   rd_exp_t       rd_q[$];
   int            drop_q[$];
   logic [DW-1:0] ref_mem [DEPTH];
   int            ref_clr;

   sap_data_ram #(.DATA_W(DW), .ADDR_W(AW)) u_dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .write_addr(write_addr),
      .data_in(data_in), .rd_en(rd_en), .read_addr(read_addr),
      .data_out(data_out), .rd_valid(rd_valid), .clr_req(clr_req),
      .busy(busy), .access_drop(access_drop)
   );

   sap_data_ram #(.DATA_W(16), .ADDR_W(6)) u_big (
      .clk(clk), .rst_n(b_rst_n), .wr_en(b_we), .write_addr(b_wa),
      .data_in(b_wd), .rd_en(b_re), .read_addr(b_ra),
      .data_out(b_do), .rd_valid(b_rv), .clr_req(b_clr),
      .busy(b_busy), .access_drop(b_drop)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pop expected read data / drop pulses when the DUT presents them.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rd_valid) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 32'(rd_valid), 32'h0);
            else begin
               rd_exp_t e;
               e = rd_q.pop_front();
               chk("rd_tag", 32'(cyc), 32'(e.tag));
               chk("rd_data", 32'(data_out), 32'(e.d));
            end
         end else if (rd_q.size() > 0 && rd_q[0].tag <= cyc) begin
            rd_exp_t e;
            e = rd_q.pop_front();
            chk("rd_missing", 32'(rd_valid), 32'h1);
         end
         if (access_drop) begin
            if (drop_q.size() == 0) chk("drop_unexpected", 32'(access_drop), 32'h0);
            else chk("drop_tag", 32'(cyc), 32'(drop_q.pop_front()));
         end else if (drop_q.size() > 0 && drop_q[0] <= cyc) begin
            void'(drop_q.pop_front());
            chk("drop_missing", 32'(access_drop), 32'h1);
         end
      end
   end

   // Reference: a clear request zeroes the whole array and blocks DEPTH cycles.
   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      ref_clr = DEPTH;
   endtask

   // One clock of stimulus; the model predicts what the next edge does.
   task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic re, input logic [AW-1:0] ra, input logic clr);
      rd_exp_t e;
      wr_en = we; write_addr = wa; data_in = wd;
      rd_en = re; read_addr = ra; clr_req = clr;
      if (ref_clr > 0) begin
         if (we || re) drop_q.push_back(cyc + 1);
         ref_clr--;
      end else begin
         if (re) begin
            e.tag = cyc + 1;
            e.d   = ref_mem[ra];
`ifdef SAP_RAM_WR_BYPASS_EN
            if (we && wa == ra) e.d = wd;
`endif
            rd_q.push_back(e);
         end
         if (we) ref_mem[wa] = wd;
         if (clr) model_clear();
      end
      @(posedge clk);
      #1;
      chk("busy", 32'(busy), 32'(ref_clr > 0));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'h1);
      chk({tag, "_rd_valid"}, 32'(rd_valid), 32'h0);
      chk({tag, "_data_out"}, 32'(data_out), 32'h0);
      chk({tag, "_drop"}, 32'(access_drop), 32'h0);
   endtask

   initial begin
      int n;
      ref_clr = DEPTH;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      #2;
      check_reset_outputs("rst");

      // 16x64 instance: clear length, top-address write/readback, address 0.
      @(posedge clk); #1;
      b_rst_n = 1'b1;
      n = 0;
      while (b_busy && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("big_clear_len", 32'(n), 32'd64);
      b_we = 1'b1; b_wa = 6'd63; b_wd = 16'hBEEF;
      @(posedge clk); #1;
      b_we = 1'b0; b_re = 1'b1; b_ra = 6'd63;
      @(posedge clk); #1;
      chk("big_rv63", 32'(b_rv), 32'h1);
      chk("big_rd63", 32'(b_do), 32'hBEEF);
      b_ra = 6'd0;
      @(posedge clk); #1;
      chk("big_rv0", 32'(b_rv), 32'h1);
      chk("big_rd0", 32'(b_do), 32'h0);
      b_re = 1'b0;
      @(posedge clk); #1;
      chk("big_rv_idle", 32'(b_rv), 32'h0);

      // Main instance: post-reset clear, then every word reads zero.
      rst_n = 1'b1;
      idle(DEPTH);
      for (int a = 0; a < DEPTH; a++) cycle(1'b0, '0, '0, 1'b1, AW'(a), 1'b0);
      idle(1);

      // Write then read; neighbour stays zero.
      cycle(1'b1, 4'd3, 8'hA5, 1'b0, '0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 4'd3, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 4'd4, 1'b0);

      // Same-address collision, then readback of the new word.
      cycle(1'b1, 4'd7, 8'h11, 1'b0, '0, 1'b0);
      cycle(1'b1, 4'd7, 8'h22, 1'b1, 4'd7, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 4'd7, 1'b0);

      // Fill with FF, clear, drop a write on the 3rd busy cycle, read back.
      for (int a = 0; a < DEPTH; a++) cycle(1'b1, AW'(a), 8'hFF, 1'b0, '0, 1'b0);
      cycle(1'b0, '0, '0, 1'b0, '0, 1'b1);
      idle(2);
      cycle(1'b1, 4'd2, 8'h5A, 1'b0, '0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 4'd9, 1'b0);
      idle(DEPTH - 4);
      cycle(1'b0, '0, '0, 1'b1, 4'd2, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 4'd5, 1'b0);

      // Reset in the middle of a clear, with a read in flight.
      cycle(1'b1, 4'd1, 8'h77, 1'b0, '0, 1'b1);
      idle(7);
      cycle(1'b0, '0, '0, 1'b1, 4'd1, 1'b0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      rd_q.delete();
      drop_q.delete();
      model_clear();
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(DEPTH);
      for (int a = 0; a < DEPTH; a++) cycle(1'b0, '0, '0, 1'b1, AW'(a), 1'b0);

      // Level clr_req with reads: clear, one idle cycle, clear again.
      for (int i = 0; i < 3 * DEPTH; i++)
         cycle(1'b1, AW'($urandom), DW'($urandom), 1'b1, AW'($urandom), 1'b1);
      idle(DEPTH + 1);

      // Random traffic with occasional clears.
      for (int i = 0; i < 600; i++)
         cycle(1'($urandom), AW'($urandom), DW'($urandom), 1'($urandom),
               AW'($urandom), ($urandom_range(0, 49) == 0));
      idle(DEPTH + 2);

      chk("rd_q_drained", 32'(rd_q.size()), 32'h0);
      chk("drop_q_drained", 32'(drop_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
